// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache: one fetch at a time from the core,
// refilling a 32-byte line from memory as a 4-beat 64-bit burst on a miss.
module inst_cache #(
   parameter int S_INDEX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_read,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_resp,
   output logic [31:0] pmem_address,
   output logic        pmem_read,
   input  logic [63:0] pmem_rdata,
   input  logic        pmem_resp,
   output logic [1:0]  dbg_state
);

   localparam int S_OFFSET = 5;
   localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
   localparam int SETS     = 1 << S_INDEX;

   typedef enum logic [1:0] {IDLE, CHECK, FILL, RESP} state_t;

   // Handshake: the core raises inst_read and holds it until the single-cycle
   // inst_resp pulse; the address is captured only on the IDLE accept edge.
   state_t            state_q, state_d;
   logic [31:2]       req_addr_q, req_addr_d;
   logic [1:0]        beat_q, beat_d;
   logic [SETS-1:0]   valid_q;
   logic [S_TAG-1:0]  tag_q [SETS];
   logic [255:0]      data_q [SETS];

   logic [S_INDEX-1:0] idx;
   logic [S_TAG-1:0]   req_tag;
   logic [2:0]         word_sel;
   logic               hit;
   logic [31:0]        line_word;
   logic               fill_we;
   logic               fill_last;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^inst_addr[1:0];

   assign idx       = req_addr_q[S_INDEX+4:5];
   assign req_tag   = req_addr_q[31:S_INDEX+5];
   assign word_sel  = req_addr_q[4:2];
   assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
   assign line_word = data_q[idx][32*word_sel +: 32];
   assign dbg_state = state_q;

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      beat_d       = beat_q;
      inst_resp    = 1'b0;
      inst_rdata   = 32'h0;
      pmem_read    = 1'b0;
      pmem_address = 32'h0;
      fill_we      = 1'b0;
      fill_last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (inst_read) begin
               req_addr_d = inst_addr[31:2];
               state_d    = CHECK;
            end
         end
         CHECK: begin
            if (hit) begin
               inst_resp  = 1'b1;
               inst_rdata = line_word;
               state_d    = IDLE;
            end else begin
               beat_d  = 2'd0;
               state_d = FILL;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {req_addr_q[31:5], 5'b0};
            if (pmem_resp) begin
               fill_we = 1'b1;
               beat_d  = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  fill_last = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            inst_resp  = 1'b1;
            inst_rdata = line_word;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset is synchronous, so quiet the outputs and array writes while it is asserted.
      if (!rst) begin
         inst_resp    = 1'b0;
         inst_rdata   = 32'h0;
         pmem_read    = 1'b0;
         pmem_address = 32'h0;
         fill_we      = 1'b0;
         fill_last    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         beat_q     <= 2'd0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         beat_q     <= beat_d;
         if (fill_last) valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) data_q[idx][64*beat_q +: 64] <= pmem_rdata;
      if (fill_last) tag_q[idx] <= req_tag;
   end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache with a burst memory responder
// and a set/tag reference model of a direct-mapped cache.
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_read = 1'b0;
   logic [31:0] inst_addr = 32'h0;
   logic [31:0] inst_rdata;
   logic        inst_resp;
   logic [31:0] pmem_address;
   logic        pmem_read;
   logic [63:0] pmem_rdata = 64'h0;
   logic        pmem_resp = 1'b0;
   logic [1:0]  dbg_state;

   inst_cache #(.S_INDEX(3)) dut (
      .clk(clk), .rst(rst), .inst_read(inst_read), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_resp(inst_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_line = 32'h0;
   int fills_done = 0;
   int rd_cycles = 0;
   int beat_n = 0;
   int last_beat_cyc = 0;
   bit          mvalid [8];
   logic [23:0] mtag [8];

   // Memory contents: line 0x40 holds word i = i*0x11111111, elsewhere a hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a[31:5] == 27'h2) w = 32'h11111111 * 32'(a[4:2]);
      else w = (a * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
      return w;
   endfunction

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   // Memory responder: beats with random gaps, stray pulses outside bursts.
   initial begin
      int gap;
      gap = $urandom_range(0, 2);
      forever begin
         @(negedge clk); #1;
         pmem_resp = 1'b0;
         if (rst === 1'b1 && pmem_read === 1'b1) begin
            rd_cycles++;
            checks++;
            if (pmem_address !== exp_line) fail("pmem_address", pmem_address, exp_line);
            if (gap > 0) gap--;
            else begin
               pmem_resp  = 1'b1;
               pmem_rdata = {mem_word(pmem_address + 32'(8*beat_n) + 32'd4),
                             mem_word(pmem_address + 32'(8*beat_n))};
               beat_n++;
               gap = $urandom_range(0, 2);
               if (beat_n == 4) begin
                  beat_n = 0;
                  fills_done++;
                  last_beat_cyc = cyc;
               end
            end
         end else begin
            beat_n = 0;
            if (rst === 1'b1 && $urandom_range(0, 7) == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = {$urandom, $urandom};
            end
         end
      end
   end

   // Monitor: pop the scoreboard on every response, else outputs must be quiet.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk); #1;
         if (rst === 1'b1) begin
            checks++;
            if (inst_resp === 1'b1) begin
               if (exp_q.size() == 0) fail("unexpected_resp", inst_rdata, 32'h0);
               else begin
                  e = exp_q.pop_front();
                  if (inst_rdata !== e) fail("inst_rdata", inst_rdata, e);
               end
            end else if (inst_resp !== 1'b0 || inst_rdata !== 32'h0) begin
               fail("quiet_outputs", inst_rdata, 32'h0);
            end
         end
      end
   end

   // One fetch; acc_off is cycles until the DUT's IDLE accept edge.
   task automatic do_fetch(input logic [31:0] a, input int acc_off, input bit chg);
      logic [2:0]  idx;
      logic [23:0] tg;
      bit hit, got;
      int f0, r0, acc;
      idx = a[7:5];
      tg  = a[31:8];
      hit = mvalid[idx] && (mtag[idx] == tg);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      exp_q.push_back(mem_word({a[31:2], 2'b00}));
      exp_line  = {a[31:5], 5'b0};
      f0 = fills_done;
      r0 = rd_cycles;
      acc = cyc + acc_off;
      inst_read = 1'b1;
      inst_addr = a;
      got = 1'b0;
      for (int t = 0; t < 80 && !got; t++) begin
         @(negedge clk); #1;
         if (chg && t == 2) inst_addr = 32'h80;
         if (inst_resp === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) fail("resp_timeout", a, 32'h1);
      else if (hit) begin
         checks++;
         if (cyc != acc) fail("hit_latency", 32'(cyc), 32'(acc));
         checks++;
         if (fills_done != f0 || rd_cycles != r0) fail("hit_pmem_activity", 32'(rd_cycles - r0), 32'h0);
      end else begin
         checks++;
         if (cyc != last_beat_cyc + 1) fail("miss_latency", 32'(cyc), 32'(last_beat_cyc + 1));
         checks++;
         if (fills_done != f0 + 1) fail("miss_fill_count", 32'(fills_done - f0), 32'h1);
      end
      inst_read = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (inst_resp !== 1'b0) fail({tag, "_inst_resp"}, 32'(inst_resp), 32'h0);
      checks++;
      if (pmem_read !== 1'b0) fail({tag, "_pmem_read"}, 32'(pmem_read), 32'h0);
      checks++;
      if (pmem_address !== 32'h0) fail({tag, "_pmem_address"}, pmem_address, 32'h0);
      checks++;
      if (inst_rdata !== 32'h0) fail({tag, "_inst_rdata"}, inst_rdata, 32'h0);
   endtask

   initial begin
      int start, g, bt;
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         mvalid[i] = 1'b0;
         mtag[i] = '0;
      end
      idle(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      idle(1);

      do_fetch(32'h44, 1, 1'b0);
      do_fetch(32'h58, 2, 1'b0);
      idle(1);
      do_fetch(32'h140, 1, 1'b0);
      do_fetch(32'h44, 2, 1'b0);
      do_fetch(32'h140, 2, 1'b0);
      do_fetch(32'h48, 2, 1'b1);
      do_fetch(32'h84, 2, 1'b0);
      do_fetch(32'h140, 2, 1'b0);

      // Reset in the middle of a line-0x40 burst.
      idle(1);
      exp_line  = 32'h40;
      inst_addr = 32'h40;
      inst_read = 1'b1;
      bt = 0;
      while (beat_n < 2 && bt < 40) begin
         @(negedge clk); #1;
         bt++;
      end
      checks++;
      if (bt >= 40) fail("midfill_timeout", 32'(beat_n), 32'h2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      inst_read = 1'b0;
      check_reset_outputs("midfill_rst");
      idle(1);
      check_reset_outputs("midfill_rst2");
      rst = 1'b1;
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      idle(1);
      do_fetch(32'h40, 1, 1'b0);
      do_fetch(32'h84, 2, 1'b0);

      start = cyc;
      for (int i = 0; i < 8; i++) do_fetch(32'h40 + 32'(4*i), 2, 1'b0);
      checks++;
      if (cyc - start > 16) fail("b2b_cycles", 32'(cyc - start), 32'd16);

      for (int n = 0; n < 300; n++) begin
         g = $urandom_range(0, 2);
         idle(g);
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         do_fetch(a, (g == 0) ? 2 : 1, ($urandom_range(0, 7) == 0));
      end

      idle(4);
      checks++;
      if (exp_q.size() != 0) fail("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Read-only, direct-mapped instruction cache between the pipelined RV32I core's fetch port and physical memory.
- Accepts one word fetch at a time from the core and returns the instruction word.
- On a miss, fills a 256-bit line from memory with a 4-beat 64-bit burst.
- Replaces the core's zero-latency instruction port with a request/response handshake so fetch can stall.

Parameters:
- S_INDEX, 3, index bits; 2^S_INDEX sets (default 8).
- S_OFFSET, 5, line offset bits (32-byte line, 8 words); fixed, not overridable.
- S_TAG, 32-S_INDEX-S_OFFSET, tag width (default 24).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge).
- inst_read  in  1  core fetch request.
- inst_addr  in  32  fetch byte address; bits [1:0] ignored.
- inst_rdata  out  32  instruction word; valid only while inst_resp==1.
- inst_resp  out  1  one-cycle response pulse.
- pmem_address  out  32  line address {tag,index,5'b0}.
- pmem_read  out  1  burst read request; held high until 4th beat.
- pmem_rdata  in  64  burst beat data.
- pmem_resp  in  1  beat valid; one pulse per beat, 4 beats per burst.

Behaviour:
- Storage: per set, valid bit, S_TAG tag, 256-bit data line. Direct mapped; a fill overwrites the set unconditionally.
- Reset (rst==0 at edge): all valid bits 0, FSM to IDLE, and address latch, beat counter and output registers cleared.
- Outputs during reset: inst_resp=0, inst_rdata=0, pmem_read=0, pmem_address=0.
- FSM states are IDLE, CHECK, FILL, RESP.
- IDLE:
  - inst_read==1 → latch inst_addr into req_addr, go to CHECK.
  - Otherwise stay.
  - Outputs idle.
- CHECK:
  - Hit means valid[idx] && tag[idx]==req_addr[31:8-S_INDEX+S_INDEX...]. Precisely: tag compared to req_addr[31:S_INDEX+5]; idx=req_addr[S_INDEX+4:5].
  - Hit → inst_resp=1 and inst_rdata=line word req_addr[4:2] this cycle, then IDLE.
  - Miss → FILL, beat counter=0.
- FILL:
  - pmem_read=1 and pmem_address={req_addr[31:5],5'b0} are held stable throughout.
  - Each pmem_resp pulse writes pmem_rdata into line bits [64k+63:64k], where k = beat counter, then increments the counter.
  - On the 4th beat (k==3): write tag, set valid, go to RESP; pmem_read drops in RESP.
- RESP: inst_resp=1, inst_rdata = requested word of the freshly filled line, then IDLE.
- Latency:
  - Hit: response 1 cycle after the accept edge, i.e. request accepted in IDLE at edge N, inst_resp high in cycle N+1.
  - Miss: inst_resp 1 cycle after the 4th pmem_resp.
  - Back-to-back hits sustain one fetch every 2 cycles.
- Handshake:
  - Core holds inst_read until inst_resp.
  - inst_addr is sampled only in IDLE; later changes before inst_resp are ignored.
  - inst_read still high in the IDLE cycle after a response is a new request.
- pmem_resp outside FILL is ignored.
- Reset mid-FILL: the line is not validated and pmem_read drops at the reset edge. The memory model drops the partial burst.
- inst_rdata is 0 whenever inst_resp==0.
- No write port, no flush. Self-modifying code is unsupported.

Test Plan:
- Cold miss:
  - Stimulus: after reset, read 0x0000_0044; memory line at 0x40 returns beats 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, 0x77777777_66666666.
  - Required: pmem_address=0x40, exactly 4 beats consumed, inst_rdata=0x11111111 with inst_resp 1 cycle after the 4th beat.
- Hit:
  - Stimulus: then read 0x0000_0058.
  - Required: no pmem_read; inst_resp 1 cycle after accept with 0x66666666.
- Conflict miss:
  - Stimulus: read 0x0000_0140 (same index as 0x40 with S_INDEX=3).
  - Required: refill from 0x140, then a read of 0x44 misses again and re-fetches line 0x40.
- Address change mid-miss:
  - Stimulus: inst_addr changed to 0x80 during FILL of 0x40.
  - Required: response word still from 0x40; pmem_address stays 0x40.
- Reset mid-fill:
  - Stimulus: rst=0 after 2 beats of line 0x40, then release and read 0x40.
  - Required: pmem_read=0 and inst_resp=0 during reset; the later read misses and does a full 4-beat fill.
- Back-to-back hits:
  - Stimulus: inst_read held high across 8 sequential words 0x40–0x5C after fill.
  - Required: 8 responses in 16 cycles, correct words in order, no pmem activity.
